// File: rtl/speed_pkg.sv
// Shared definitions for the game-speed selection interface: speed codes,
// round FSM state encoding and the speed-to-period mapping.
package speed_pkg;

    localparam logic [1:0] SPEED_NORMAL = 2'b00;
    localparam logic [1:0] SPEED_INTER  = 2'b01;
    localparam logic [1:0] SPEED_ADV    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The unused code 2'b11 is treated as normal speed.
    function automatic logic [1:0] speed_norm(input logic [1:0] speed);
        return (speed == 2'b11) ? SPEED_NORMAL : speed;
    endfunction

    function automatic int unsigned speed_period(input logic [1:0] speed,
                                                 input int unsigned p_normal,
                                                 input int unsigned p_inter,
                                                 input int unsigned p_adv);
        case (speed)
            SPEED_INTER: return p_inter;
            SPEED_ADV:   return p_adv;
            default:     return p_normal;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Down-counting prescaler: reloads itself on reaching zero and emits a
// registered one-cycle pulse for every wrap.
module tick_prescaler #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             wrap,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Combinational wrap lets the parent update its round state on the same edge.
    assign wrap = enable && !load && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            zero <= 1'b0;
        end else begin
            zero <= wrap;
            if (load) begin
                cnt <= load_val;
            end else if (enable) begin
                cnt <= wrap ? load_val : cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/speed_tick_gen.sv
// Round timer: latches the selected speed and emits ROUND_TICKS tick pulses.
// Define SPEED_RAMP_EN to shorten the period every 10th tick within a round.
module speed_tick_gen
    import speed_pkg::*;
#(
    parameter int unsigned TICK_NORMAL = 50_000_000,
    parameter int unsigned TICK_INTER  = 25_000_000,
    parameter int unsigned TICK_ADV    = 12_500_000,
    parameter int unsigned ROUND_TICKS = 30,
    parameter int          CNT_W       = 26,
    parameter int          RT_W        = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      game_speed,
    input  logic            control,
    input  logic            pause,
    output logic            tick,
    output logic [RT_W-1:0] ticks_left,
    output logic            running,
    output logic            round_done,
    output logic [1:0]      speed_q
);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] base_period;
    logic [CNT_W-1:0] cur_period;
    logic [CNT_W-1:0] load_val;
    logic             load;
    logic             enable;
    logic             wrap;
    logic             zero;

    assign base_period = CNT_W'(speed_period(speed_norm(game_speed),
                                             TICK_NORMAL, TICK_INTER, TICK_ADV));

    // Gating with control means an abort edge can never produce a tick.
    assign load     = (state == LOAD);
    assign enable   = (state == RUN) && control && !pause;
    assign load_val = load ? base_period - CNT_W'(1) : cur_period - CNT_W'(1);

    tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .enable   (enable),
        .wrap     (wrap),
        .zero     (zero)
    );

    assign tick       = zero;
    assign running    = (state == RUN);
    assign round_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (control) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: begin
                if (!control) begin
                    state_d = IDLE;
                end else if (wrap && ticks_left == RT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: if (!control) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SPEED_RAMP_EN
    logic [3:0]       ramp_cnt;
    logic [CNT_W-1:0] ramp_next;
    logic [CNT_W-1:0] ramp_floor;

    assign ramp_floor = CNT_W'(TICK_ADV / 2);
    assign ramp_next  = cur_period - (cur_period >> 3);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            ticks_left <= '0;
            speed_q    <= SPEED_NORMAL;
            cur_period <= CNT_W'(TICK_NORMAL);
`ifdef SPEED_RAMP_EN
            ramp_cnt   <= '0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    speed_q    <= speed_norm(game_speed);
                    cur_period <= base_period;
                    ticks_left <= RT_W'(ROUND_TICKS);
`ifdef SPEED_RAMP_EN
                    ramp_cnt   <= '0;
`endif
                end
                RUN: begin
                    if (!control) begin
                        ticks_left <= '0;
                    end else if (wrap) begin
                        ticks_left <= ticks_left - RT_W'(1);
`ifdef SPEED_RAMP_EN
                        // New period applies from the following interval.
                        if (ramp_cnt == 4'd9) begin
                            ramp_cnt   <= '0;
                            cur_period <= (ramp_next < ramp_floor) ? ramp_floor : ramp_next;
                        end else begin
                            ramp_cnt <= ramp_cnt + 4'd1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_speed_tick_gen.sv
// Directed bench for speed_tick_gen with shortened periods (8/4/2) and
// three ticks per round.
module tb_speed_tick_gen;
    import speed_pkg::*;

    localparam int RT_W = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      game_speed;
    logic            control;
    logic            pause;
    logic            tick;
    logic [RT_W-1:0] ticks_left;
    logic            running;
    logic            round_done;
    logic [1:0]      speed_q;

    int n_checks = 0;
    int n_pass   = 0;

    speed_tick_gen #(
        .TICK_NORMAL (8),
        .TICK_INTER  (4),
        .TICK_ADV    (2),
        .ROUND_TICKS (3),
        .CNT_W       (26),
        .RT_W        (RT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .game_speed (game_speed),
        .control    (control),
        .pause      (pause),
        .tick       (tick),
        .ticks_left (ticks_left),
        .running    (running),
        .round_done (round_done),
        .speed_q    (speed_q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until tick is seen; cycles stays 0 if the budget runs out.
    task automatic wait_tick(input int budget, output int cycles);
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (tick === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic start_round(input logic [1:0] spd);
        game_speed = spd;
        control    = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; control = 1'b1; game_speed = 2'b01; pause = 1'b0;
        step();
        step();
        n_checks++; if (tick !== 1'b0) $display("FAIL reset_tick: got %0b expected 0", tick); else n_pass++;
        n_checks++; if (ticks_left !== '0) $display("FAIL reset_ticks_left: got %0d expected 0", ticks_left); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL reset_running: got %0b expected 0", running); else n_pass++;
        n_checks++; if (round_done !== 1'b0) $display("FAIL reset_round_done: got %0b expected 0", round_done); else n_pass++;
        n_checks++; if (speed_q !== 2'b00) $display("FAIL reset_speed_q: got %0d expected 0", speed_q); else n_pass++;
        n_checks++; if (dut.state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); else n_pass++;
        rst = 1'b1;
        step();
        n_checks++; if (dut.state !== LOAD) $display("FAIL release_load: got %0d expected %0d", dut.state, LOAD); else n_pass++;
        step();
        n_checks++; if (running !== 1'b1) $display("FAIL release_run: got %0b expected 1", running); else n_pass++;
        control = 1'b0;
        step();
        n_checks++; if (dut.state !== IDLE) $display("FAIL release_abort: got %0d expected %0d", dut.state, IDLE); else n_pass++;
    endtask

    task automatic test_speed01();
        int c;
        start_round(2'b01);
        n_checks++; if (ticks_left !== RT_W'(3)) $display("FAIL s01_start_left: got %0d expected 3", ticks_left); else n_pass++;
        n_checks++; if (speed_q !== 2'b01) $display("FAIL s01_speed_q: got %0d expected 1", speed_q); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            wait_tick(20, c);
            n_checks++; if (c != 4) $display("FAIL s01_period_%0d: got %0d expected 4", k, c); else n_pass++;
            n_checks++; if (ticks_left !== RT_W'(3 - k)) $display("FAIL s01_left_%0d: got %0d expected %0d", k, ticks_left, 3 - k); else n_pass++;
        end
        n_checks++; if (round_done !== 1'b1) $display("FAIL s01_done: got %0b expected 1", round_done); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL s01_running: got %0b expected 0", running); else n_pass++;
        step();
        n_checks++; if (tick !== 1'b0) $display("FAIL s01_tick_single: got %0b expected 0", tick); else n_pass++;
        n_checks++; if (round_done !== 1'b1) $display("FAIL s01_done_hold: got %0b expected 1", round_done); else n_pass++;
        control = 1'b0;
        step();
        n_checks++; if (round_done !== 1'b0) $display("FAIL s01_done_clear: got %0b expected 0", round_done); else n_pass++;
        n_checks++; if (dut.state !== IDLE) $display("FAIL s01_idle: got %0d expected %0d", dut.state, IDLE); else n_pass++;
    endtask

    task automatic test_speed11_abort();
        int c;
        int seen;
        start_round(2'b11);
        n_checks++; if (speed_q !== 2'b00) $display("FAIL s11_speed_q: got %0d expected 0", speed_q); else n_pass++;
        wait_tick(30, c);
        n_checks++; if (c != 8) $display("FAIL s11_period: got %0d expected 8", c); else n_pass++;
        n_checks++; if (ticks_left !== RT_W'(2)) $display("FAIL s11_left: got %0d expected 2", ticks_left); else n_pass++;
        control = 1'b0;
        step();
        n_checks++; if (dut.state !== IDLE) $display("FAIL abort_state: got %0d expected %0d", dut.state, IDLE); else n_pass++;
        n_checks++; if (ticks_left !== '0) $display("FAIL abort_left: got %0d expected 0", ticks_left); else n_pass++;
        n_checks++; if (round_done !== 1'b0) $display("FAIL abort_done: got %0b expected 0", round_done); else n_pass++;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (tick !== 1'b0) seen++;
            step();
        end
        n_checks++; if (seen != 0) $display("FAIL abort_no_tick: got %0d ticks expected 0", seen); else n_pass++;
    endtask

    task automatic test_pause();
        int c;
        int bad;
        start_round(2'b10);
        n_checks++; if (ticks_left !== RT_W'(3)) $display("FAIL restart_left: got %0d expected 3", ticks_left); else n_pass++;
        n_checks++; if (speed_q !== 2'b10) $display("FAIL s10_speed_q: got %0d expected 2", speed_q); else n_pass++;
        wait_tick(20, c);
        n_checks++; if (c != 2) $display("FAIL s10_period: got %0d expected 2", c); else n_pass++;
        // Pause lands on the cycle where the prescaler sits at zero.
        step();
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tick !== 1'b0 || ticks_left !== RT_W'(2)) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL pause_hold: got %0d bad cycles expected 0", bad); else n_pass++;
        pause = 1'b0;
        wait_tick(20, c);
        n_checks++; if (c != 1) $display("FAIL pause_delay: got %0d expected 1", c); else n_pass++;
        n_checks++; if (ticks_left !== RT_W'(1)) $display("FAIL pause_left: got %0d expected 1", ticks_left); else n_pass++;
    endtask

    task automatic test_abort_vs_final();
        step();
        control = 1'b0;
        step();
        n_checks++; if (tick !== 1'b0) $display("FAIL final_abort_tick: got %0b expected 0", tick); else n_pass++;
        n_checks++; if (round_done !== 1'b0) $display("FAIL final_abort_done: got %0b expected 0", round_done); else n_pass++;
        n_checks++; if (dut.state !== IDLE) $display("FAIL final_abort_state: got %0d expected %0d", dut.state, IDLE); else n_pass++;
        n_checks++; if (ticks_left !== '0) $display("FAIL final_abort_left: got %0d expected 0", ticks_left); else n_pass++;
        step();
        n_checks++; if (round_done !== 1'b0) $display("FAIL final_abort_done2: got %0b expected 0", round_done); else n_pass++;
    endtask

    task automatic test_toggle_reset_in_done();
        int c;
        logic [1:0] alt;
        start_round(2'b01);
        for (int k = 1; k <= 3; k++) begin
            c = 0;
            for (int i = 1; i <= 20; i++) begin
                alt = (i % 2 == 1) ? 2'b10 : 2'b00;
                game_speed = alt;
                step();
                if (tick === 1'b1) begin
                    c = i;
                    break;
                end
            end
            n_checks++; if (c != 4) $display("FAIL toggle_period_%0d: got %0d expected 4", k, c); else n_pass++;
        end
        n_checks++; if (speed_q !== 2'b01) $display("FAIL toggle_speed_q: got %0d expected 1", speed_q); else n_pass++;
        n_checks++; if (round_done !== 1'b1) $display("FAIL toggle_done: got %0b expected 1", round_done); else n_pass++;
        rst = 1'b0;
        control = 1'b0;
        step();
        n_checks++; if (round_done !== 1'b0) $display("FAIL rst_done_clear: got %0b expected 0", round_done); else n_pass++;
        n_checks++; if (speed_q !== 2'b00) $display("FAIL rst_speed_q: got %0d expected 0", speed_q); else n_pass++;
        n_checks++; if (dut.state !== IDLE) $display("FAIL rst_state: got %0d expected %0d", dut.state, IDLE); else n_pass++;
        rst = 1'b1;
        step();
        n_checks++; if (dut.state !== IDLE) $display("FAIL rst_stay_idle: got %0d expected %0d", dut.state, IDLE); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_speed01();
        test_speed11_abort();
        test_pause();
        test_abort_vs_final();
        test_toggle_reset_in_done();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/speed_tick_gen.md
Name: speed_tick_gen

Overview:
Consumer end of the game-speed selection interface. Waits for the selection-ready flag (control), latches the 2-bit game speed, then runs one game round. A round is a fixed number of tick pulses, spaced by a speed-dependent period. Ticks drive the random-number/LED stepping logic; round_done tells the game controller that the round time has expired.

Parameters:
- TICK_NORMAL, 50_000_000: clk cycles per tick for speed 2'b00.
- TICK_INTER, 25_000_000: clk cycles per tick for speed 2'b01.
- TICK_ADV, 12_500_000: clk cycles per tick for speed 2'b10.
- ROUND_TICKS, 30: ticks per round.
- CNT_W, 26: prescaler width; must hold the largest TICK_* minus 1.
- RT_W, 6: ticks_left width; must hold ROUND_TICKS.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-low reset.
- game_speed, in, 2: level from the selector (00 normal, 01 intermediate, 10 advanced).
- control, in, 1: selection valid; stays high until the selector is reset.
- pause, in, 1: freezes the round while high.
- tick, out, 1: one-cycle pulse per elapsed period.
- ticks_left, out, RT_W: ticks remaining in the round.
- running, out, 1: high in RUN.
- round_done, out, 1: high in DONE.
- speed_q, out, 2: latched speed currently in use.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, tick=0, ticks_left=0, running=0, round_done=0, speed_q=2'b00, prescaler=0. Reset has priority in every state, including mid-round.
- IDLE: outputs idle. If control==1, go to LOAD; otherwise stay.
- LOAD (1 cycle):
  - speed_q <= game_speed; 2'b11 maps to 2'b00.
  - prescaler <= period(speed)-1; ticks_left <= ROUND_TICKS.
  - Go to RUN.
- RUN: running=1.
  - Each cycle with pause==0:
    - If prescaler != 0, decrement it.
    - If prescaler == 0, reload period-1, assert tick next cycle (registered), and decrement ticks_left.
  - With pause==1: prescaler and ticks_left hold; no tick is issued.
  - First tick is visible exactly P cycles after the first RUN cycle (P = period), then every P unpaused cycles.
  - When a reload takes ticks_left from 1 to 0, go to DONE. The final tick pulse still fires, coincident with the first DONE cycle.
  - If control drops to 0 in RUN, abort to IDLE next cycle: no tick, ticks_left=0.
  - game_speed changes during RUN are ignored; only speed_q is used.
- DONE: round_done=1, running=0, ticks_left=0. Stay while control==1. Go to IDLE when control==0.
- A new round therefore requires control to fall and rise again.
- Simultaneous events:
  - pause and the prescaler reaching 0 in the same cycle: pause wins; the tick is deferred.
  - control falling and the final tick in the same cycle: abort wins; no round_done.

Optional Feature:
- Macro SPEED_RAMP_EN.
- Defined: every 10th tick in a round, the active period is reduced by period>>3, floored at TICK_ADV/2, so the game accelerates within a round. LOAD restores the base period.
- Undefined: the period stays constant for the whole round.

Decomposition:
- Shared package speed_pkg holds:
  - The speed encodings (SPEED_NORMAL=2'b00, SPEED_INTER=2'b01, SPEED_ADV=2'b10). The selector must also use these.
  - The state encoding (IDLE, LOAD, RUN, DONE).
  - A function mapping speed to period.
- Sub-module tick_prescaler:
  - Inputs: load, load_val, enable.
  - Output: a registered zero-reached pulse.
  - Instantiated once.

Test Plan:
Bench overrides: TICK_NORMAL=8, TICK_INTER=4, TICK_ADV=2, ROUND_TICKS=3.
1. Reset: hold rst=0 for 2 cycles with control=1 -> all outputs 0, state IDLE; after release -> LOAD then RUN.
2. game_speed=01, control rises -> ticks 4 cycles apart, ticks_left 3,2,1,0, round_done=1 after the 3rd tick, running=0.
3. game_speed=11 -> speed_q=00, tick period 8 cycles.
4. Speed 10 run, pause high for 5 cycles between ticks -> next tick delayed by exactly 5 cycles, ticks_left unchanged during pause.
5. control drops mid-RUN after 1 tick -> IDLE next cycle, ticks_left=0, no round_done; control re-rises -> new round with ticks_left=3.
6. rst=0 asserted in DONE -> round_done=0 next cycle; game_speed toggled during RUN -> period unaffected.
